// File: rtl/eight_bit_adder_pkg.sv
// Shared constants, result record and helper for the 8-bit ripple-carry adder.
package eight_bit_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] sum;
        logic                     cout;
        logic                     ovf;
        logic                     zero;
    } add_result_t;

    // True when every bit of the value is clear.
    function automatic logic is_zero(input logic [DEFAULT_WIDTH-1:0] value);
        return (value == {DEFAULT_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/eight_bit_adder_full_adder.sv
// One-bit full-adder cell used as a link of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/eight_bit_adder.sv
// 8-bit ripple-carry adder with a zero-latency combinational result and a
// registered copy annotated with carry, signed-overflow and zero flags.
module eight_bit_adder
    import eight_bit_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             zero_q,
    output logic             out_valid
);

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    add_result_t      result_s;
    add_result_t      result_r;
    logic             out_valid_r;

    assign carry_s[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_ripple
            full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (carry_s[i]),
                .s    (sum_s[i]),
                .cout (carry_s[i+1])
            );
        end
    endgenerate

    // Assemble the flag-annotated result; overflow is carry into vs out of the sign bit.
    always_comb begin
        result_s      = '0;
        result_s.sum  = sum_s;
        result_s.cout = carry_s[WIDTH];
        result_s.ovf  = carry_s[WIDTH] ^ carry_s[WIDTH-1];
        result_s.zero = is_zero(sum_s);
    end

    // Output register: reset wins, valid input captures, otherwise data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r    <= '0;
            out_valid_r <= 1'b0;
        end else if (in_valid) begin
            result_r    <= result_s;
            out_valid_r <= 1'b1;
        end else begin
            result_r    <= result_r;
            out_valid_r <= 1'b0;
        end
    end

    assign sum       = result_s.sum;
    assign cout      = result_s.cout;
    assign sum_q     = result_r.sum;
    assign cout_q    = result_r.cout;
    assign ovf_q     = result_r.ovf;
    assign zero_q    = result_r.zero;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_eight_bit_adder.sv
// Self-checking bench for eight_bit_adder: directed vector table, hand-written
// registered-path sequences and randomized stimulus against an arithmetic model.
module tb_eight_bit_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       in_valid;
    logic [7:0] sum;
    logic       cout;
    logic [7:0] sum_q;
    logic       cout_q;
    logic       ovf_q;
    logic       zero_q;
    logic       out_valid;

    int errors = 0;
    int checks = 0;

    eight_bit_adder dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .sum_q     (sum_q),
        .cout_q    (cout_q),
        .ovf_q     (ovf_q),
        .zero_q    (zero_q),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [7];

    // Expected registered state held by the model between captures.
    logic [7:0] m_sum;
    logic       m_cout;
    logic       m_ovf;
    logic       m_zero;
    logic       m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [7:0] e_sum, input logic e_cout,
                              input logic e_ovf, input logic e_zero, input logic e_valid);
        check({tag, " sum_q"},     {24'd0, sum_q},     {24'd0, e_sum});
        check({tag, " cout_q"},    {31'd0, cout_q},    {31'd0, e_cout});
        check({tag, " ovf_q"},     {31'd0, ovf_q},     {31'd0, e_ovf});
        check({tag, " zero_q"},    {31'd0, zero_q},    {31'd0, e_zero});
        check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, e_valid});
    endtask

    // Reference: plain integer addition; overflow from signed range of the true result.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mc,
                         output logic [7:0] r_sum, output logic r_cout, output logic r_ovf);
        int total;
        int stotal;
        total  = int'(ma) + int'(mb) + int'(mc);
        stotal = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
        r_sum  = total[7:0];
        r_cout = (total > 255);
        r_ovf  = (stotal > 127) || (stotal < -128);
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[2] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'hAB, 8'hCD, 1'b1, 8'h79, 1'b1, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_regs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Directed vectors, each captured with in_valid for one cycle.
        for (int i = 0; i < 7; i++) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; in_valid = 1'b1;
            #1;
            check($sformatf("vec%0d sum", i),  {24'd0, sum},  {24'd0, vecs[i].exp_sum});
            check($sformatf("vec%0d cout", i), {31'd0, cout}, {31'd0, vecs[i].exp_cout});
            @(posedge clk); #1;
            check_regs($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout,
                       vecs[i].exp_ovf, (vecs[i].exp_sum == 8'h00), 1'b1);
        end

        // in_valid low: out_valid drops, data holds, combinational path follows inputs.
        in_valid = 1'b0; a = 8'h10; b = 8'h22; cin = 1'b1;
        @(posedge clk); #1;
        check_regs("hold", 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        check("hold comb sum", {24'd0, sum}, 32'h0000_0033);

        // Reset with in_valid high clears; combinational outputs unaffected.
        a = 8'hF0; b = 8'h20; cin = 1'b0; in_valid = 1'b1; rst = 1'b1;
        #1;
        check("rst comb sum",  {24'd0, sum},  32'h0000_0010);
        check("rst comb cout", {31'd0, cout}, 32'h0000_0001);
        @(posedge clk); #1;
        check_regs("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Randomized traffic against the arithmetic model.
        m_sum = 8'h00; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0; m_valid = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic [7:0] r_sum;
            logic       r_cout;
            logic       r_ovf;
            a        = 8'($urandom_range(0, 255));
            b        = 8'($urandom_range(0, 255));
            cin      = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 15) == 0);
            model(a, b, cin, r_sum, r_cout, r_ovf);
            #1;
            check("rnd sum",  {24'd0, sum},  {24'd0, r_sum});
            check("rnd cout", {31'd0, cout}, {31'd0, r_cout});
            if (rst) begin
                m_sum = 8'h00; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0; m_valid = 1'b0;
            end else if (in_valid) begin
                m_sum = r_sum; m_cout = r_cout; m_ovf = r_ovf; m_zero = (r_sum == 8'h00); m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            @(posedge clk); #1;
            check_regs("rnd", m_sum, m_cout, m_ovf, m_zero, m_valid);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
